// File: rtl/vcu108_user_io_pkg.sv
// Shared defaults for the VCU108 user I/O block: channel counts, debounce
// length and LED brightness width, plus the debounce counter width helper.
package vcu108_user_io_pkg;

  localparam int DEF_NUM_SWITCHES    = 4;
  localparam int DEF_NUM_BUTTONS     = 5;
  localparam int DEF_NUM_LEDS        = 8;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_PWM_BITS        = 4;

  // Counter must hold 0 .. cycles-1 and never wrap; keep at least one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/vcu108_debounce_channel.sv
// One debounced input bit: 2-flop synchroniser, stability counter, stable
// level flop and one-cycle rise/fall pulses aligned with the stable change.
module vcu108_debounce_channel
  import vcu108_user_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             sync1_d, sync1_q;
  logic             sync2_d, sync2_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             stable_d, stable_q;
  logic             rise_d, rise_q;
  logic             fall_d, fall_q;

  // Next-state: count cycles the synced level differs, commit on the last one.
  always_comb begin
    sync1_d  = pin_i;
    sync2_d  = sync1_q;
    cnt_d    = CNT_ZERO;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
        fall_d   = ~sync2_q;
        cnt_d    = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= CNT_ZERO;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

// File: rtl/vcu108_user_io.sv
// VCU108 user I/O: debounced switches/buttons with press/release pulses and
// registered LED drive. Define VCU108_USER_IO_PWM_EN to enable per-LED PWM
// brightness; otherwise LEDs follow led_state and led_brightness is ignored.
module vcu108_user_io
  import vcu108_user_io_pkg::*;
#(
  parameter int NUM_SWITCHES    = DEF_NUM_SWITCHES,
  parameter int NUM_BUTTONS     = DEF_NUM_BUTTONS,
  parameter int NUM_LEDS        = DEF_NUM_LEDS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PWM_BITS        = DEF_PWM_BITS
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_SWITCHES-1:0]      vcu108_inputs__switches,
  input  logic [NUM_BUTTONS-1:0]       vcu108_inputs__buttons,
  output logic [NUM_SWITCHES-1:0]      switches_stable,
  output logic [NUM_BUTTONS-1:0]       buttons_stable,
  output logic [NUM_BUTTONS-1:0]       button_pressed,
  output logic [NUM_BUTTONS-1:0]       button_released,
  input  logic [NUM_LEDS-1:0]          led_state,
  input  logic [NUM_LEDS*PWM_BITS-1:0] led_brightness,
  output logic [NUM_LEDS-1:0]          vcu108_leds__leds
);

  // Switch edges are not exported; the names mark them as intentionally dropped.
  logic [NUM_SWITCHES-1:0] switch_rise_unused_s;
  logic [NUM_SWITCHES-1:0] switch_fall_unused_s;

  for (genvar gi = 0; gi < NUM_SWITCHES; gi++) begin : g_sw
    vcu108_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .pin_i   (vcu108_inputs__switches[gi]),
      .stable_o(switches_stable[gi]),
      .rise_o  (switch_rise_unused_s[gi]),
      .fall_o  (switch_fall_unused_s[gi])
    );
  end

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
    vcu108_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .pin_i   (vcu108_inputs__buttons[gi]),
      .stable_o(buttons_stable[gi]),
      .rise_o  (button_pressed[gi]),
      .fall_o  (button_released[gi])
    );
  end

  logic [NUM_LEDS-1:0] leds_d, leds_q;

`ifdef VCU108_USER_IO_PWM_EN
  logic [PWM_BITS-1:0] pwm_d, pwm_q;
  logic [PWM_BITS-1:0] br_s [NUM_LEDS];

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_br
    assign br_s[gi] = led_brightness[gi*PWM_BITS +: PWM_BITS];
  end

  // Free-running PWM phase; full-scale brightness means always on.
  always_comb begin
    pwm_d  = pwm_q + PWM_BITS'(1);
    leds_d = {NUM_LEDS{1'b0}};
    for (int i = 0; i < NUM_LEDS; i++) begin
      leds_d[i] = led_state[i] &
                  ((br_s[i] == {PWM_BITS{1'b1}}) | (pwm_q < br_s[i]));
    end
  end

  // PWM phase counter, wraps naturally at 2^PWM_BITS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_q <= {PWM_BITS{1'b0}};
    end else begin
      pwm_q <= pwm_d;
    end
  end
`else
  logic brightness_unused_s;
  assign brightness_unused_s = ^led_brightness;

  // Without PWM the LEDs simply follow the requested on/off state.
  always_comb begin
    leds_d = led_state;
  end
`endif

  // Registered LED pin drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      leds_q <= {NUM_LEDS{1'b0}};
    end else begin
      leds_q <= leds_d;
    end
  end

  assign vcu108_leds__leds = leds_q;

endmodule

// File: tb/tb_vcu108_user_io.sv
// Scoreboard bench for vcu108_user_io with DEBOUNCE_CYCLES=8, PWM_BITS=4.
// Stimulus pushes expected stable-level / LED changes with their due cycle;
// the monitor pops them when due and compares every output each cycle.
module tb_vcu108_user_io;

  localparam int NS  = 4;
  localparam int NB  = 5;
  localparam int NL  = 8;
  localparam int D   = 8;
  localparam int PB  = 4;
  localparam int LAT = D + 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NS-1:0]    sw = '0;
  logic [NB-1:0]    bt = '0;
  logic [NS-1:0]    sw_stable;
  logic [NB-1:0]    bt_stable;
  logic [NB-1:0]    bt_pressed;
  logic [NB-1:0]    bt_released;
  logic [NL-1:0]    led_state = '0;
  logic [NL*PB-1:0] led_br = '0;
  logic [NL-1:0]    leds;

  vcu108_user_io #(
    .NUM_SWITCHES(NS), .NUM_BUTTONS(NB), .NUM_LEDS(NL),
    .DEBOUNCE_CYCLES(D), .PWM_BITS(PB)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .vcu108_inputs__switches(sw),
    .vcu108_inputs__buttons (bt),
    .switches_stable        (sw_stable),
    .buttons_stable         (bt_stable),
    .button_pressed         (bt_pressed),
    .button_released        (bt_released),
    .led_state              (led_state),
    .led_brightness         (led_br),
    .vcu108_leds__leds      (leds)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int           at;
    int           kind;  // 0 switch, 1 button, 2 leds
    int           idx;
    logic         val;
    logic [NL-1:0] leds;
  } ev_t;

  ev_t sb[$];

  logic [NS-1:0] exp_sw = '0;
  logic [NB-1:0] exp_bt = '0;
  logic [NB-1:0] exp_pr = '0;
  logic [NB-1:0] exp_rl = '0;
  logic [NL-1:0] exp_leds = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Monitor: count edges, retire due events, compare all outputs.
  always @(posedge clk) begin
    int k;
    cyc++;
    #1;
    exp_pr = '0;
    exp_rl = '0;
    if (!reset_n) begin
      sb.delete();
      exp_sw   = '0;
      exp_bt   = '0;
      exp_leds = '0;
    end else begin
      k = 0;
      while (k < sb.size()) begin
        if (sb[k].at == cyc) begin
          case (sb[k].kind)
            0: exp_sw[sb[k].idx] = sb[k].val;
            1: begin
              if (sb[k].val && !exp_bt[sb[k].idx]) exp_pr[sb[k].idx] = 1'b1;
              if (!sb[k].val && exp_bt[sb[k].idx]) exp_rl[sb[k].idx] = 1'b1;
              exp_bt[sb[k].idx] = sb[k].val;
            end
            default: exp_leds = sb[k].leds;
          endcase
          sb.delete(k);
        end else begin
          k++;
        end
      end
    end
    chk("switches_stable", 32'(sw_stable), 32'(exp_sw));
    chk("buttons_stable", 32'(bt_stable), 32'(exp_bt));
    chk("button_pressed", 32'(bt_pressed), 32'(exp_pr));
    chk("button_released", 32'(bt_released), 32'(exp_rl));
`ifndef VCU108_USER_IO_PWM_EN
    chk("leds", 32'(leds), 32'(exp_leds));
`endif
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Held pin change: expected stable change LAT edges later.
  task automatic set_bt(input int idx, input logic v);
    bt[idx] = v;
    sb.push_back('{cyc + LAT, 1, idx, v, '0});
  endtask

  task automatic set_sw(input int idx, input logic v);
    sw[idx] = v;
    sb.push_back('{cyc + LAT, 0, idx, v, '0});
  endtask

  task automatic set_leds(input logic [NL-1:0] v);
    led_state = v;
    sb.push_back('{cyc + 1, 2, 0, 1'b0, v});
  endtask

`ifdef VCU108_USER_IO_PWM_EN
  int on_cnt [NL];
`endif

  initial begin
    // Reset state (monitor compares against zeros while reset is low).
    step(3);
    chk("reset_leds", 32'(leds), 32'd0);
    chk("reset_bt_stable", 32'(bt_stable), 32'd0);
    reset_n = 1'b1;
    step(2);

    // Button0 press held, then released.
    set_bt(0, 1'b1);
    step(14);
    set_bt(0, 1'b0);
    step(14);

    // Button1 glitch of 5 cycles: no change expected.
    bt[1] = 1'b1;
    step(5);
    bt[1] = 1'b0;
    step(14);

    // Switch2 and button3 together, up then down.
    set_sw(2, 1'b1);
    set_bt(3, 1'b1);
    step(14);
    set_sw(2, 1'b0);
    set_bt(3, 1'b0);
    step(14);

    // Several channels simultaneously.
    set_bt(2, 1'b1);
    set_bt(4, 1'b1);
    set_sw(0, 1'b1);
    step(14);
    set_bt(2, 1'b0);
    set_bt(4, 1'b0);
    set_sw(0, 1'b0);
    step(14);

    // Boundary: held D-1 cycles rejected, held exactly D cycles accepted.
    bt[1] = 1'b1;
    step(D - 1);
    bt[1] = 1'b0;
    step(14);
    set_bt(1, 1'b1);
    step(D);
    set_bt(1, 1'b0);
    step(20);

`ifdef VCU108_USER_IO_PWM_EN
    // PWM duty: LED0=4, LED1=0, LED2=15 (always on), others 0.
    led_state = 8'hFF;
    led_br    = 32'h0000_0F04;
    step(3);
    for (int i = 0; i < NL; i++) on_cnt[i] = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NL; i++) on_cnt[i] += int'(leds[i]);
    end
    chk("pwm_led0_on", 32'(on_cnt[0]), 32'd4);
    chk("pwm_led1_on", 32'(on_cnt[1]), 32'd0);
    chk("pwm_led2_on", 32'(on_cnt[2]), 32'd16);
    chk("pwm_led3_on", 32'(on_cnt[3]), 32'd0);
    led_state = 8'h00;
    step(3);
`else
    // LEDs follow led_state one cycle later, brightness ignored.
    led_br = (NL*PB)'($urandom());
    set_leds(8'hA5);
    step(3);
    led_br = (NL*PB)'($urandom());
    step(2);
    set_leds(8'h3C);
    step(3);
    set_leds(8'h00);
    step(3);
`endif

    // Reset at count 5 of a button1 press, pin held high through reset.
    bt[1] = 1'b1;
    step(7);
    reset_n = 1'b0;
    step(3);
    chk("midreset_bt_stable", 32'(bt_stable), 32'd0);
    reset_n = 1'b1;
    sb.push_back('{cyc + LAT, 1, 1, 1'b1, '0});
    step(14);
    set_bt(1, 1'b0);
    step(14);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/vcu108_user_io.md
VCU108_USER_IO -- requirements
Module: vcu108_user_io

Interface
REQ-001 SHALL have parameter NUM_SWITCHES, default 4, switch channel count.
REQ-002 SHALL have parameter NUM_BUTTONS, default 5, button channel count.
REQ-003 SHALL have parameter NUM_LEDS, default 8, LED channel count.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required (min 2).
REQ-005 SHALL have parameter PWM_BITS, default 4, per-LED brightness width.
REQ-006 SHALL have port clk  in  1  single clock for all logic.
REQ-007 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port vcu108_inputs__switches  in  NUM_SWITCHES  raw asynchronous switch pins.
REQ-009 SHALL have port vcu108_inputs__buttons  in  NUM_BUTTONS  raw asynchronous button pins.
REQ-010 SHALL have port switches_stable  out  NUM_SWITCHES  debounced switch levels.
REQ-011 SHALL have port buttons_stable  out  NUM_BUTTONS  debounced button levels.
REQ-012 SHALL have port button_pressed  out  NUM_BUTTONS  one-cycle pulse on debounced 0->1.
REQ-013 SHALL have port button_released  out  NUM_BUTTONS  one-cycle pulse on debounced 1->0.
REQ-014 SHALL have port led_state  in  NUM_LEDS  requested LED on/off.
REQ-015 SHALL have port led_brightness  in  NUM_LEDS*PWM_BITS  per-LED duty, LED i at bits [i*PWM_BITS +: PWM_BITS].
REQ-016 SHALL have port vcu108_leds__leds  out  NUM_LEDS  registered LED pin drive.

Function
REQ-017 Each switch/button bit SHALL pass a 2-flop synchroniser before any other use.
REQ-018 Per channel: counter clears whenever synced value equals stable value; increments while they differ.
REQ-019 When counter = DEBOUNCE_CYCLES-1 and synced still differs, stable SHALL take synced value and counter SHALL clear on that edge.
REQ-020 Pin change held steady SHALL appear on *_stable exactly 2+DEBOUNCE_CYCLES cycles after the first sampling edge.
REQ-021 Any differing run shorter than DEBOUNCE_CYCLES SHALL leave stable unchanged (counter restarts from 0).
REQ-022 button_pressed/button_released SHALL be asserted in the same cycle the stable bit first shows its new value, for exactly one cycle.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce simultaneous pulses.
REQ-024 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); counter SHALL never wrap.
REQ-025 LED output SHALL be registered: value reflects led_state/led_brightness sampled on the previous edge.

Reset
REQ-026 reset_n low SHALL immediately clear synchronisers, counters, *_stable, pulse outputs, PWM counter and vcu108_leds__leds to 0.
REQ-027 Reset mid-debounce SHALL discard partial counts; a pin held high through reset SHALL produce stable=1 and one pressed pulse 2+DEBOUNCE_CYCLES cycles after release.

Configuration
REQ-028 Macro VCU108_USER_IO_PWM_EN SHALL control brightness.
REQ-029 With it: free-running PWM_BITS counter p (wraps 2^PWM_BITS-1 -> 0); LED i on when led_state[i] and (brightness = all-ones or p < brightness); brightness 0 = off.
REQ-030 Without it: no PWM counter; vcu108_leds__leds = registered led_state; led_brightness ignored.

Structure
REQ-031 Package vcu108_user_io_pkg SHALL hold default parameter constants (counts, DEBOUNCE_CYCLES, PWM_BITS).
REQ-032 Sub-module vcu108_debounce_channel (synchroniser, counter, stable flop, edge pulses, one bit) SHALL be instantiated per switch and per button.

Verification (DEBOUNCE_CYCLES=8, PWM_BITS=4)
REQ-033 Button0 0->1 held -> buttons_stable[0]=1 and button_pressed[0] single pulse 10 cycles after first sampling edge.
REQ-034 Button1 high 5 cycles then low -> no change on stable, no pulses.
REQ-035 Switch2 and button3 toggle same cycle -> both stable bits change same cycle; button_released[3] pulses if going low.
REQ-036 Reset asserted at count 5 of a button press, released with pin still high -> pressed pulse 10 cycles after release, not earlier.
REQ-037 PWM_EN, led_state=0xFF, brightness LED0=4, LED1=0, LED2=15 -> over 16 cycles LED0 on 4, LED1 on 0, LED2 on 16.
REQ-038 PWM_EN undefined, led_state=0xA5 -> vcu108_leds__leds=0xA5 one cycle later regardless of brightness.
